// File: rtl/piso_sched.sv
// piso_sched: round-robin (PISO_SCHED_RR_EN) or fixed-priority scheduler that loads and shifts one word at a time into a PISO register
module piso_sched #(
  parameter int M   = 8,
  parameter int N   = 4,
  parameter int DIV = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req_valid,
  input  logic [N*M-1:0]         req_data,
  output logic [N-1:0]           req_ready,
  output logic [M-1:0]           sr_bus,
  output logic                   sr_set,
  output logic                   sr_shift,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic                   busy,
  output logic                   frame_done
);
  localparam int GW = $clog2(N);
  localparam int BW = $clog2(M + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [M-1:0]    bus_q, bus_d;
  logic [GW-1:0]   gid_q, gid_d;
  logic [GW-1:0]   ptr, win, idx;
  logic            xfer;
`ifdef PISO_SCHED_RR_EN
  logic [GW-1:0]   rr_q, rr_d;
  assign ptr  = rr_q;
  assign rr_d = xfer ? GW'((int'(win) + 1) % N) : rr_q;
  // round-robin pointer advances past each winner
  always_ff @(posedge clk or negedge reset)
    if (!reset) rr_q <= '0;
    else        rr_q <= rr_d;
`else
  assign ptr = '0;
`endif
  // first asserted request at or after ptr, searched downward so the nearest one wins
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = GW'((int'(ptr) + k) % N);
      if (req_valid[idx]) win = idx;
    end
  end
  assign xfer       = (state_q == IDLE) && (|req_valid);
  assign req_ready  = (xfer && reset) ? (N'(1) << win) : '0;
  assign sr_bus     = bus_q;
  assign grant_id   = gid_q;
  assign sr_set     = state_q == LOAD;
  assign sr_shift   = (state_q == SHIFT) && (div_q == DW'(DIV - 1));
  assign busy       = state_q != IDLE;
  assign frame_done = state_q == DONE;
  // frame sequencing: capture word, load strobe, M paced shifts, done pulse
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    bus_d   = bus_q;
    gid_d   = gid_q;
    case (state_q)
      IDLE: if (xfer) begin
        bus_d   = req_data[int'(win)*M +: M];
        gid_d   = win;
        state_d = LOAD;
      end
      LOAD: begin
        div_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: if (sr_shift) begin
        div_d   = '0;
        bit_d   = bit_q + 1'b1;
        state_d = (bit_q == BW'(M - 1)) ? DONE : SHIFT;
      end else begin
        div_d   = div_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      bus_q   <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      bus_q   <= bus_d;
      gid_q   <= gid_d;
    end
endmodule
